// File: rtl/sc_dmem_pkg.sv
// sc_dmem_pkg: shared types and constants for the data-memory arbiter.
//   state_e    : arbiter ownership state (IDLE, OWN0, OWN1)
//   DMEM_WORDS : RAM depth in 32-bit words
//   word_idx() : byte address -> RAM word index (addr[6:2])
package sc_dmem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DMEM_WORDS = 32;
  localparam int unsigned WADDR_LSB  = 2;
  localparam int unsigned WADDR_MSB  = 6;
  localparam int unsigned WIDX_W     = WADDR_MSB - WADDR_LSB + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_e;

  // Word index the RAM decodes from a byte address.
  function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[WADDR_MSB:WADDR_LSB];
  endfunction

endpackage

// File: rtl/sc_rr_pick2.sv
// sc_rr_pick2: combinational two-way pick.
//   i_req0/i_req1 : requests
//   i_prio        : favoured port when both request and no hold (0 = port 0)
//   i_hold        : current owner keeps the grant on contention
//   i_holder      : port that owns the hold (0 = port 0)
//   o_gnt0_c/o_gnt1_c : one-hot (or zero) grant
module sc_rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  input  logic i_hold,
  input  logic i_holder,
  output logic o_gnt0_c,
  output logic o_gnt1_c
);

  logic w_winner;

  // Contention winner: the lock holder if a hold is active, else round-robin prio.
  assign w_winner = i_hold ? i_holder : i_prio;

  assign o_gnt0_c = i_req0 & (~i_req1 | ~w_winner);
  assign o_gnt1_c = i_req1 & (~i_req0 |  w_winner);

endmodule

// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: round-robin two-port arbiter in front of the single-ported
// data RAM, with a bounded per-port lock (burst).
//   clk, reset                 : clock, async active-high reset
//   mN_req/we/lock/addr/wdata  : port N request side (N = 0 CPU, 1 debug/DMA)
//   mN_gnt                     : combinational grant, access completes at this edge
//   mN_rdata/mN_rvalid         : registered read data, one-cycle valid pulse
//   mem_we/mem_addr/mem_datain : RAM write/address/data, muxed from the granted port
//   mem_dataout                : async RAM read data
module sc_dmem_arbiter
  import sc_dmem_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

  state_e            r_state;
  logic              r_prio;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;

  logic w_hold;
  logic w_holder;
  logic w_pick0;
  logic w_pick1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_own_cont;

  // Owner keeps the RAM only while still locked and under the burst bound.
  assign w_hold   = ((r_state == S_OWN0 && m0_lock) || (r_state == S_OWN1 && m1_lock))
                    && (r_burst_cnt < CNT_MAX);
  assign w_holder = (r_state == S_OWN1);

  sc_rr_pick2 u_pick (
    .i_req0   (m0_req),
    .i_req1   (m1_req),
    .i_prio   (r_prio),
    .i_hold   (w_hold),
    .i_holder (w_holder),
    .o_gnt0_c (w_pick0),
    .o_gnt1_c (w_pick1)
  );

  // Suppress grants during reset so an in-flight write never reaches the RAM.
  assign w_gnt0 = w_pick0 & ~reset;
  assign w_gnt1 = w_pick1 & ~reset;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Granted port continues a run it already owned.
  assign w_own_cont = (w_gnt0 && r_state == S_OWN0) || (w_gnt1 && r_state == S_OWN1);

  // RAM port mux; zero when idle.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    if (w_gnt0) begin
      mem_we     = m0_we;
      mem_addr   = m0_addr;
      mem_datain = m0_wdata;
    end else if (w_gnt1) begin
      mem_we     = m1_we;
      mem_addr   = m1_addr;
      mem_datain = m1_wdata;
    end
  end

  // FSM, round-robin pointer, burst counter and read return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_burst_cnt <= '0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      r_m1_rvalid <= w_gnt1 & ~m1_we;
      if (w_gnt0 && !m0_we) r_m0_rdata <= mem_dataout;
      if (w_gnt1 && !m1_we) r_m1_rdata <= mem_dataout;

      if (w_gnt0 || w_gnt1) begin
        // Favour the port that was not just served.
        r_prio <= w_gnt0;
        if (w_gnt0) r_state <= m0_lock ? S_OWN0 : S_IDLE;
        else        r_state <= m1_lock ? S_OWN1 : S_IDLE;
        if (w_own_cont)
          r_burst_cnt <= (r_burst_cnt == CNT_MAX) ? CNT_MAX : r_burst_cnt + CNT_W'(1);
        else
          r_burst_cnt <= '0;
      end else begin
        r_state     <= S_IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;

endmodule
